// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MLP datapath: FSM state encoding, pipeline depth
// and the shift/saturate range check used on accumulator outputs.
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PIPE_DEPTH = 3;
  localparam int SAT_MAXW   = 128;

  // Returns {clip_high, clip_low} for acc >>> frac against an out_w-bit signed range.
  function automatic logic [1:0] sat_code(input logic signed [SAT_MAXW-1:0] acc,
                                          input int frac, input int out_w);
    logic signed [SAT_MAXW-1:0] sh;
    logic signed [SAT_MAXW-1:0] hi;
    logic signed [SAT_MAXW-1:0] lo;
    sh = acc >>> frac;
    hi = (SAT_MAXW'(1) << (out_w - 1)) - SAT_MAXW'(1);
    lo = ~hi;
    return {sh > hi, sh < lo};
  endfunction

endpackage

// File: rtl/dot_adder_tree.sv
// Registered binary adder tree: sums LANES signed IN_W operands with one cycle of latency.
module dot_adder_tree #(
  parameter int LANES = 4,
  parameter int IN_W  = 32
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [LANES*IN_W-1:0]                  i_data,
  output logic signed [IN_W+$clog2(LANES)-1:0]   o_sum
);

  localparam int OUT_W = IN_W + $clog2(LANES);

  // Heap-indexed tree: leaves at LANES-1.., node i sums children 2i+1 and 2i+2.
  logic signed [OUT_W-1:0] w_node [2*LANES-1];
  logic signed [OUT_W-1:0] r_sum;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_node[LANES-1+k] = OUT_W'($signed(i_data[k*IN_W +: IN_W]));
    end
    for (int i = LANES - 2; i >= 0; i--) begin
      w_node[i] = w_node[2*i+1] + w_node[2*i+2];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sum <= '0;
    else          r_sum <= w_node[0];
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/dot_product_engine.sv
// Streaming signed fixed-point dot product: multiply -> adder tree -> accumulate -> shift/saturate.
// Build option DOTP_RELU_EN clamps negative results to zero after saturation.
module dot_product_engine import mlp_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int LANES     = 4,
  parameter int MAX_BEATS = 256,
  parameter int ACC_W     = 48
) (
  input  logic                               CLK,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [$clog2(MAX_BEATS+1)-1:0]     len,
  output logic                               busy,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [LANES*DATA_W-1:0]            vec_a,
  input  logic [LANES*DATA_W-1:0]            vec_b,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_W-1:0]                  result,
  output logic                               sat
);

  localparam int LEN_W  = $clog2(MAX_BEATS + 1);
  localparam int PROD_W = 2 * DATA_W;
  localparam int TREE_W = PROD_W + $clog2(LANES);
  localparam logic [DATA_W-1:0] RES_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] RES_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                    r_state;
  logic [LEN_W-1:0]          r_beats_left;
  logic                      r_busy, r_in_ready, r_out_valid, r_sat;
  logic [DATA_W-1:0]         r_result;
  logic [LANES*PROD_W-1:0]   r_prod;
  logic [PIPE_DEPTH-1:0]     r_pipe_v;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [TREE_W-1:0]  w_tree_sum;
  logic [1:0]                w_clip;
  logic [DATA_W-1:0]         w_res;
  logic                      w_xfer, w_start;

  assign w_xfer  = in_valid && r_in_ready;
  assign w_start = (r_state == IDLE) && start;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_prod <= '0;
    end else if (w_xfer) begin
      for (int k = 0; k < LANES; k++) begin
        r_prod[k*PROD_W +: PROD_W] <= PROD_W'($signed(vec_a[k*DATA_W +: DATA_W]))
                                    * PROD_W'($signed(vec_b[k*DATA_W +: DATA_W]));
      end
    end
  end

  dot_adder_tree #(.LANES(LANES), .IN_W(PROD_W)) u_tree (
    .i_clk   (CLK),
    .i_rst_n (reset_n),
    .i_data  (r_prod),
    .o_sum   (w_tree_sum)
  );

  // r_pipe_v bit n marks valid data leaving stage n+1; all zero means fully drained.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe_v <= '0;
      r_acc    <= '0;
    end else begin
      r_pipe_v <= {r_pipe_v[PIPE_DEPTH-2:0], w_xfer};
      if (w_start)          r_acc <= '0;
      else if (r_pipe_v[1]) r_acc <= r_acc + ACC_W'(w_tree_sum);
    end
  end

  assign w_clip = sat_code(SAT_MAXW'(r_acc), FRAC_BITS, DATA_W);

  always_comb begin
    w_res = r_acc[FRAC_BITS +: DATA_W];
    if (w_clip[1])      w_res = RES_MAX;
    else if (w_clip[0]) w_res = RES_MIN;
`ifdef DOTP_RELU_EN
    if (w_res[DATA_W-1]) w_res = '0;
`else
`endif
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_beats_left <= '0;
      r_busy       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_sat        <= 1'b0;
      r_result     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_busy       <= 1'b1;
            r_beats_left <= len;
            if (len == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= '0;
              r_sat       <= 1'b0;
            end else begin
              r_state    <= RUN;
              r_in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_xfer) begin
            r_beats_left <= r_beats_left - 1'b1;
            if (r_beats_left == LEN_W'(1)) begin
              r_in_ready <= 1'b0;
              r_state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (r_pipe_v == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_sat       <= |w_clip;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign sat       = r_sat;

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench for dot_product_engine: directed cases plus random vectors
// against an arithmetic reference model (honours DOTP_RELU_EN).
module tb_dot_product_engine;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int VW     = LANES * DATA_W;

  logic          CLK = 1'b0;
  logic          reset_n, start, in_valid, out_ready;
  logic [8:0]    len;
  logic [VW-1:0] vec_a, vec_b;
  logic          busy, in_ready, out_valid, sat;
  logic [15:0]   result;

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] qa[$];
  logic [VW-1:0] qb[$];

  dot_product_engine dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .vec_a(vec_a), .vec_b(vec_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .sat(sat)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product, floor shift, clip, optional ReLU.
  function automatic void model(input int nb, output logic [15:0] res, output logic s);
    longint acc = 0;
    longint sh;
    logic [VW-1:0] ta, tb;
    for (int b = 0; b < nb; b++) begin
      ta = qa[b];
      tb = qb[b];
      for (int k = 0; k < LANES; k++)
        acc += longint'($signed(ta[k*DATA_W +: DATA_W])) * longint'($signed(tb[k*DATA_W +: DATA_W]));
    end
    sh = acc >>> 8;
    s = 1'b0;
    if (sh > 32767)       begin sh = 32767;  s = 1'b1; end
    else if (sh < -32768) begin sh = -32768; s = 1'b1; end
`ifdef DOTP_RELU_EN
    if (sh < 0) sh = 0;
`endif
    res = sh[15:0];
  endfunction

  task automatic fill(input int nb, input logic [15:0] a, input logic [15:0] b);
    qa.delete(); qb.delete();
    for (int i = 0; i < nb; i++) begin
      qa.push_back({LANES{a}});
      qb.push_back({LANES{b}});
    end
  endtask

  task automatic run_vec(input string tag, input int nb, input bit gaps, input int hold,
                         input bit noise);
    logic [15:0] exp_res, r0;
    logic        exp_sat, s0, rdy, vld;
    int sent, guard, lat;
    model(nb, exp_res, exp_sat);
    start = 1'b1; len = 9'(nb);
    @(posedge CLK); #1;
    start = noise;
    chk({tag, "_busy_start"}, busy, 1);
    if (nb == 0) begin
      chk({tag, "_len0_in_ready"}, in_ready, 0);
      chk({tag, "_len0_out_valid"}, out_valid, 1);
    end else begin
      sent = 0; guard = 0;
      while (sent < nb && guard < 300) begin
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        vec_a = qa[sent]; vec_b = qb[sent];
        rdy = in_ready; vld = in_valid;
        @(posedge CLK); #1;
        guard++;
        if (rdy && vld) sent++;
      end
      in_valid = 1'b0; start = 1'b0;
      chk({tag, "_beats"}, sent, nb);
      chk({tag, "_in_ready_off"}, in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge CLK); #1;
        lat++;
      end
      chk({tag, "_latency"}, lat, 4);
    end
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_sat"}, sat, exp_sat);
    r0 = result; s0 = sat;
    repeat (hold) begin
      @(posedge CLK); #1;
    end
    if (hold > 0) begin
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_busy"}, busy, 1);
      chk({tag, "_hold_result"}, {result, sat}, {r0, s0});
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    chk({tag, "_accept_valid"}, out_valid, 0);
    chk({tag, "_accept_busy"}, busy, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b1;
    vec_a = '0; vec_b = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_outputs", {busy, in_ready, out_valid, sat, result}, '0);
    reset_n = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;

    fill(2, 16'h0100, 16'h0200);
    run_vec("basic", 2, 1'b0, 0, 1'b0);

    fill(1, 16'hFF00, 16'h0180);
    run_vec("negative", 1, 1'b0, 0, 1'b0);

    fill(4, 16'h7FFF, 16'h7FFF);
    run_vec("sat_pos", 4, 1'b0, 0, 1'b0);

    fill(4, 16'h8000, 16'h7FFF);
    run_vec("sat_neg", 4, 1'b0, 0, 1'b0);

    fill(2, 16'h0100, 16'h0200);
    run_vec("backpressure", 2, 1'b1, 5, 1'b1);

    fill(0, 16'h0000, 16'h0000);
    run_vec("len0", 0, 1'b0, 2, 1'b0);

    // Abort mid-run: reset lands between clock edges after the first beat.
    fill(4, 16'h0300, 16'h0300);
    start = 1'b1; len = 9'd4;
    @(posedge CLK); #1;
    start = 1'b0;
    in_valid = 1'b1; vec_a = qa[0]; vec_b = qb[0];
    @(posedge CLK); #1;
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {busy, in_ready, out_valid, sat, result}, '0);
    #2 reset_n = 1'b1;
    @(posedge CLK); #1;
    fill(2, 16'h0100, 16'h0200);
    run_vec("after_reset", 2, 1'b0, 1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int nb;
      logic [VW-1:0] va, vb;
      nb = $urandom_range(1, 6);
      qa.delete(); qb.delete();
      for (int i = 0; i < nb; i++) begin
        for (int k = 0; k < LANES; k++) begin
          if (r % 2 == 0) begin
            va[k*DATA_W +: DATA_W] = 16'($urandom_range(0, 4095) - 2048);
            vb[k*DATA_W +: DATA_W] = 16'($urandom_range(0, 4095) - 2048);
          end else begin
            va[k*DATA_W +: DATA_W] = 16'($urandom);
            vb[k*DATA_W +: DATA_W] = 16'($urandom);
          end
        end
        qa.push_back(va);
        qb.push_back(vb);
      end
      run_vec($sformatf("rand%0d", r), nb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
